// File: rtl/vga_timing_xga_split.sv
// Free-running 1024x768 VGA timing generator at a 64 MHz pixel clock.
// The beam position is kept in split form: x = x_hi*32 + x_lo and y = y_hi*48 + y_lo.
module vga_timing_xga_split #(
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic [4:0] x_lo,
  output logic [5:0] x_hi,
  output logic [5:0] y_lo,
  output logic [4:0] y_hi,
  output logic       line_start,
  output logic       vblank_start
);

  logic [4:0] x_lo_n;
  logic [5:0] x_hi_n;
  logic [5:0] y_lo_n;
  logic [4:0] y_hi_n;
  logic       x_lo_end;
  logic       x_end;
  logic       y_lo_end;
  logic       y_end;
  logic       hsync_act;
  logic       vsync_act;
  logic       blank_n;
  logic       line_start_n;
  logic       vblank_start_n;

  assign x_lo_end = (x_lo == 5'd31);
  assign x_end    = x_lo_end && (x_hi == 6'd41);
  assign y_lo_end = (y_lo == 6'd47);
  assign y_end    = (y_hi == 5'd16) && (y_lo == 6'd37);

  always_comb begin
    x_lo_n = x_lo + 5'd1;
    x_hi_n = x_hi;
    y_lo_n = y_lo;
    y_hi_n = y_hi;
    if (x_end) begin
      x_hi_n = 6'd0;
      if (y_end) begin
        y_lo_n = 6'd0;
        y_hi_n = 5'd0;
      end else if (y_lo_end) begin
        y_lo_n = 6'd0;
        y_hi_n = y_hi + 5'd1;
      end else begin
        y_lo_n = y_lo + 6'd1;
      end
    end else if (x_lo_end) begin
      x_hi_n = x_hi + 6'd1;
    end
  end

  // Flags decode the next position so they line up with the registered counters.
  assign hsync_act      = ((x_hi_n == 6'd32) && (x_lo_n >= 5'd24)) ||
                          ((x_hi_n >= 6'd33) && (x_hi_n <= 6'd36));
  assign vsync_act      = (y_hi_n == 5'd16) && (y_lo_n >= 6'd3) && (y_lo_n <= 6'd8);
  assign blank_n        = (x_hi_n >= 6'd32) || (y_hi_n == 5'd16);
  assign line_start_n   = (x_hi_n == 6'd0) && (x_lo_n == 5'd0);
  assign vblank_start_n = line_start_n && (y_hi_n == 5'd16) && (y_lo_n == 6'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_lo         <= 5'd0;
      x_hi         <= 6'd0;
      y_lo         <= 6'd0;
      y_hi         <= 5'd0;
      hsync        <= ~H_SYNC_POL;
      vsync        <= ~V_SYNC_POL;
      blank        <= 1'b0;
      line_start   <= 1'b1;
      vblank_start <= 1'b0;
    end else begin
      x_lo         <= x_lo_n;
      x_hi         <= x_hi_n;
      y_lo         <= y_lo_n;
      y_hi         <= y_hi_n;
      hsync        <= hsync_act ? H_SYNC_POL : ~H_SYNC_POL;
      vsync        <= vsync_act ? V_SYNC_POL : ~V_SYNC_POL;
      blank        <= blank_n;
      line_start   <= line_start_n;
      vblank_start <= vblank_start_n;
    end
  end

endmodule

// File: tb/tb_vga_timing_xga_split.sv
// Directed bench for vga_timing_xga_split: a table of probe points plus a per-cycle reference model.
// Long vertical stretches are skipped by forcing the y counters of both instances.
module tb_vga_timing_xga_split;

  logic       clk;
  logic       rst_n;
  logic       hsync, vsync, blank, line_start, vblank_start;
  logic [4:0] x_lo;
  logic [5:0] x_hi;
  logic [5:0] y_lo;
  logic [4:0] y_hi;
  logic       hsync1, vsync1, blank1, line_start1, vblank_start1;
  logic [4:0] x_lo1;
  logic [5:0] x_hi1;
  logic [5:0] y_lo1;
  logic [4:0] y_hi1;

  vga_timing_xga_split dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .blank(blank),
    .x_lo(x_lo), .x_hi(x_hi), .y_lo(y_lo), .y_hi(y_hi),
    .line_start(line_start), .vblank_start(vblank_start)
  );

  vga_timing_xga_split #(.H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .hsync(hsync1), .vsync(vsync1), .blank(blank1),
    .x_lo(x_lo1), .x_hi(x_hi1), .y_lo(y_lo1), .y_hi(y_hi1),
    .line_start(line_start1), .vblank_start(vblank_start1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int jfrom;  // line on which to jump (at x = 10), -1 for none
    int jto;
    int x;
    int y;
    int hs;
    int vs;
    int bl;
    int ls;
    int vbs;
  } vec_t;

  int passed = 0;
  int total = 0;
  int mx = 0;
  int my = 0;
  bit mon_en = 1'b0;
  int mon_errs = 0;
  int hlow = 0;
  logic [4:0] fyh;
  logic [5:0] fyl;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (model x=%0d y=%0d)", name, act, exp, mx, my);
  endtask

  task automatic monitor();
    bit hs_act, vs_act;
    int e;
    hs_act = (mx >= 1048) && (mx <= 1183);
    vs_act = (my >= 771) && (my <= 776);
    e = 0;
    if (int'(x_hi) * 32 + int'(x_lo) != mx) e++;
    if (int'(y_hi) * 48 + int'(y_lo) != my) e++;
    if (x_hi > 6'd41) e++;
    if (hsync != !hs_act) e++;
    if (vsync != !vs_act) e++;
    if (hsync1 != hs_act) e++;
    if (vsync1 != vs_act) e++;
    if (blank != ((mx >= 1024) || (my >= 768))) e++;
    if (line_start != (mx == 0)) e++;
    if (vblank_start != ((mx == 0) && (my == 768))) e++;
    if (int'(x_hi1) * 32 + int'(x_lo1) != mx || int'(y_hi1) * 48 + int'(y_lo1) != my) e++;
    if (e != 0) begin
      if (mon_errs < 5)
        $display("monitor: %0d differences at model x=%0d y=%0d (dut x_hi=%0d x_lo=%0d y_hi=%0d y_lo=%0d)",
                 e, mx, my, x_hi, x_lo, y_hi, y_lo);
      mon_errs++;
    end
    if (my == 5 && hsync == 1'b0) hlow++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      mx = 0;
      my = 0;
      mon_en = 1'b1;
    end else if (mx == 1343) begin
      mx = 0;
      my = (my == 805) ? 0 : my + 1;
    end else begin
      mx++;
    end
    @(negedge clk);
    if (mon_en) monitor();
  endtask

  task automatic advance_to(input int tx, input int ty);
    int n;
    n = 0;
    while (!(mx == tx && my == ty) && n < 20000) begin
      tick();
      n++;
    end
    if (!(mx == tx && my == ty)) check("advance_timeout", n, -1);
  endtask

  // Jump both instances to line ny right after a negedge sample.
  task automatic jump(input int ny);
    fyh = 5'(ny / 48);
    fyl = 6'(ny % 48);
    force dut.y_hi = fyh;
    force dut.y_lo = fyl;
    force dut1.y_hi = fyh;
    force dut1.y_lo = fyl;
    #1;
    release dut.y_hi;
    release dut.y_lo;
    release dut1.y_hi;
    release dut1.y_lo;
    my = ny;
  endtask

  vec_t vecs[24];

  initial begin
    vecs = '{
      '{-1,  -1,    1,   0, 1, 1, 0, 0, 0},
      '{-1,  -1,   31,   0, 1, 1, 0, 0, 0},
      '{-1,  -1,   32,   0, 1, 1, 0, 0, 0},
      '{-1,  -1, 1023,   0, 1, 1, 0, 0, 0},
      '{-1,  -1, 1024,   0, 1, 1, 1, 0, 0},
      '{-1,  -1, 1047,   0, 1, 1, 1, 0, 0},
      '{-1,  -1, 1048,   0, 0, 1, 1, 0, 0},
      '{-1,  -1, 1183,   0, 0, 1, 1, 0, 0},
      '{-1,  -1, 1184,   0, 1, 1, 1, 0, 0},
      '{-1,  -1, 1343,   0, 1, 1, 1, 0, 0},
      '{-1,  -1,    0,   1, 1, 1, 0, 1, 0},
      '{-1,  -1, 1048,   5, 0, 1, 1, 0, 0},
      '{-1,  -1, 1184,   5, 1, 1, 1, 0, 0},
      '{-1,  -1,    0,   6, 1, 1, 0, 1, 0},
      '{ 6, 767, 1343, 767, 1, 1, 1, 0, 0},
      '{-1,  -1,    0, 768, 1, 1, 1, 1, 1},
      '{-1,  -1,    0, 770, 1, 1, 1, 1, 0},
      '{-1,  -1,    0, 771, 1, 0, 1, 1, 0},
      '{-1,  -1, 1100, 776, 0, 0, 1, 0, 0},
      '{-1,  -1,    0, 777, 1, 1, 1, 1, 0},
      '{778, 805, 1343, 805, 1, 1, 1, 0, 0},
      '{-1,  -1,    0,   0, 1, 1, 0, 1, 0},
      '{ 1,  46, 1343,  47, 1, 1, 1, 0, 0},
      '{-1,  -1,    0,  48, 1, 1, 0, 1, 0}
    };

    // Reset held for three clocks.
    rst_n = 1'b0;
    tick();
    tick();
    tick();
    check("rst_x", int'(x_hi) * 32 + int'(x_lo), 0);
    check("rst_y", int'(y_hi) * 48 + int'(y_lo), 0);
    check("rst_hsync", int'(hsync), 1);
    check("rst_vsync", int'(vsync), 1);
    check("rst_blank", int'(blank), 0);
    check("rst_line_start", int'(line_start), 1);
    check("rst_vblank_start", int'(vblank_start), 0);
    check("rst_hsync_pol1", int'(hsync1), 0);
    rst_n = 1'b1;
    tick();
    check("release_x", int'(x_hi) * 32 + int'(x_lo), 1);
    check("release_line_start", int'(line_start), 0);

    for (int i = 0; i < 24; i++) begin
      if (vecs[i].jfrom >= 0) begin
        advance_to(10, vecs[i].jfrom);
        jump(vecs[i].jto);
      end
      advance_to(vecs[i].x, vecs[i].y);
      check($sformatf("v%0d_x_hi", i), int'(x_hi), vecs[i].x / 32);
      check($sformatf("v%0d_x_lo", i), int'(x_lo), vecs[i].x % 32);
      check($sformatf("v%0d_y_hi", i), int'(y_hi), vecs[i].y / 48);
      check($sformatf("v%0d_y_lo", i), int'(y_lo), vecs[i].y % 48);
      check($sformatf("v%0d_hsync", i), int'(hsync), vecs[i].hs);
      check($sformatf("v%0d_vsync", i), int'(vsync), vecs[i].vs);
      check($sformatf("v%0d_blank", i), int'(blank), vecs[i].bl);
      check($sformatf("v%0d_line_start", i), int'(line_start), vecs[i].ls);
      check($sformatf("v%0d_vblank_start", i), int'(vblank_start), vecs[i].vbs);
    end

    check("hsync_low_width_line5", hlow, 136);

    // Reset in the middle of horizontal and vertical sync.
    advance_to(10, 48);
    jump(773);
    advance_to(1100, 773);
    check("midsync_hsync", int'(hsync), 0);
    check("midsync_vsync", int'(vsync), 0);
    check("midsync_hsync_pol1", int'(hsync1), 1);
    rst_n = 1'b0;
    tick();
    check("midrst_x_hi", int'(x_hi), 0);
    check("midrst_x_lo", int'(x_lo), 0);
    check("midrst_y_hi", int'(y_hi), 0);
    check("midrst_y_lo", int'(y_lo), 0);
    check("midrst_hsync", int'(hsync), 1);
    check("midrst_vsync", int'(vsync), 1);
    check("midrst_blank", int'(blank), 0);
    check("midrst_line_start", int'(line_start), 1);
    check("midrst_hsync_pol1", int'(hsync1), 0);
    check("midrst_vsync_pol1", int'(vsync1), 0);
    rst_n = 1'b1;
    tick();
    check("midrst_release_x", int'(x_hi) * 32 + int'(x_lo), 1);
    advance_to(1048, 0);
    check("pol1_hsync_1048", int'(hsync1), 1);
    advance_to(1184, 0);
    check("pol1_hsync_1184", int'(hsync1), 0);

    check("monitor_errors", mon_errs, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_timing_xga_split.md
# vga_timing_xga_split

Free-running 1024x768 (XGA) VGA timing generator for the TinyQV VGA console peripheral, clocked directly at the 64 MHz project clock. It sits directly upstream of the console renderer and supplies sync, blanking and beam position. Position is emitted in split form (x = x_hi·32 + x_lo, y = y_hi·48 + y_lo), so the renderer decodes regions with small gate counts and no multipliers. It also provides single-cycle line and frame strobes for interrupt generation.

## Interface
- H_SYNC_POL, default 0: active level of hsync (0 = active-low, XGA standard).
- V_SYNC_POL, default 0: active level of vsync.
- clk  input  1  pixel clock, 64 MHz.
- rst_n  input  1  reset: synchronous, active-low; clock clk.
- hsync  output  1  horizontal sync, registered.
- vsync  output  1  vertical sync, registered.
- blank  output  1  high outside the 1024x768 visible area, registered.
- x_lo  output  5  x mod 32.
- x_hi  output  6  x div 32, range 0..41.
- y_lo  output  6  y mod 48.
- y_hi  output  5  y div 48, range 0..16.
- line_start  output  1  one-cycle pulse while x = 0.
- vblank_start  output  1  one-cycle pulse while x = 0 and y = 768.

## Operation
- Horizontal: 1344 clocks per line (42·32). Visible 0..1023; front porch 1024..1047; sync 1048..1183; back porch 1184..1343.
- Vertical: 806 lines per frame (16·48 + 38). Visible 0..767; front porch 768..770; sync 771..776; back porch 777..805.
- x counter: x_lo increments every clock. At x_lo = 31, x_lo wraps to 0 and x_hi increments. At x_hi = 41 and x_lo = 31, x_hi and x_lo both go to 0 and the y counter advances.
- y counter advances only on horizontal wrap. y_lo increments; at y_lo = 47, y_lo wraps to 0 and y_hi increments. At y_hi = 16 and y_lo = 37 (y = 805), y_lo and y_hi both go to 0.
- All outputs are flops. hsync, vsync, blank, line_start and vblank_start are computed from the next-state counter values, so every output in cycle n describes the position shown in cycle n. There is no skew between position and flags.
- blank = (x_hi ≥ 32) | (y_hi == 16).
- hsync active when x_hi = 32 and x_lo ≥ 24, or when 33 ≤ x_hi ≤ 36.
- vsync active when y_hi = 16 and 3 ≤ y_lo ≤ 8.
- Active level of each sync is set by its *_POL parameter; the inactive level is the complement.
- x_hi never takes values 42..63. y_hi never exceeds 16. y_lo never exceeds 37 while y_hi = 16.
- Reset state, in the cycle after rst_n is sampled low:
  - all counters 0;
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL;
  - blank = 0;
  - line_start = 1, vblank_start = 0 (position 0,0 is a line start).
- Reset asserted mid-frame (including during sync) forces the reset state on the next edge. No partial-line completion.

## Timing
- Frame period 1344·806 = 1,083,264 clocks, ≈ 59.08 Hz at 64 MHz; line rate ≈ 47.62 kHz.
- Latency from rst_n deassertion: x = 1 on the first clock edge sampling rst_n high.
- hsync active width 136 clocks; vsync active width 6 lines (8064 clocks).
- vblank_start occurs exactly once per frame; line_start occurs 806 times per frame.
- No inputs besides clk and rst_n, so no handshake. Output is free-running.

## Test plan
- Reset: hold rst_n low 3 clocks -> x = 0, y = 0, hsync = 1, vsync = 1, blank = 0, line_start = 1. Release -> x = 1 after one edge, line_start = 0.
- Line wrap: run to x = 1343 on line 0 -> next cycle x_hi = 0, x_lo = 0, y_lo = 1, line_start = 1. Check x_hi never exceeds 41.
- Horizontal decode on line 5:
  - blank rises at x = 1024 and falls at x = 0;
  - hsync goes low at x = 1048 and high at x = 1184;
  - low width exactly 136 clocks.
- Vertical decode:
  - vblank_start pulses only at y = 768, x = 0 (y_hi = 16, y_lo = 0);
  - vsync is low for lines 771..776 inclusive, all x;
  - blank is high for the full lines 768..805.
- Frame wrap: at y = 805, x = 1343 -> next cycle all counters 0. Count 1,083,264 clocks between consecutive vblank_start pulses. Check y_lo wraps 47 -> 0 with a y_hi increment at y = 47 -> 48.
- Reset mid-sync: assert rst_n during vsync at y = 773, x = 1100 -> next cycle reset state exactly. Also run with H_SYNC_POL = 1: hsync is 0 after reset and 1 during x = 1048..1183.
